fetch_sequencer: RTL and testbench

- Owns the program counter and drives the address input of the synchronous instruction memory. That memory has a 1-cycle registered read.
- Sequences fetch/issue for the non-pipelined core and tells the core when the instruction word is valid.
- On the core's completion pulse, selects the next PC from these sources: PC+4, PC-relative branch (B, CBZ/CBNZ) or register target (BR).
- Traps misaligned or out-of-range targets into a sticky fault state.

---
 rtl/fetch_sequencer_pkg.sv | 26 ++
 rtl/fetch_sequencer_next_pc_calc.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared constants for the fetch sequencer slice: default datapath width,
//   instruction length, the PC increment derived from it, and the encoding
//   of the fetch/issue/fault state machine.
//   No ports (package).
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  // Default datapath / address width of the core.
  localparam int WORD_BITS = 64;

  // Fixed instruction length in bits.
  localparam int INSTR_LEN = 32;

  // Sequential fetch advances by one instruction, in bytes.
  localparam int PC_INC = INSTR_LEN / 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    FETCH_S = 2'd0,
    ISSUE_S = 2'd1,
    FAULT_S = 2'd2
  } fetch_state_e;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer_next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
//   Purely combinational next-PC selection and target checking.
//   Priority: register branch, then unconditional branch, then taken
//   conditional branch, otherwise sequential PC + 4. Branch offsets are
//   word offsets (scaled by 4). All arithmetic is modulo 2^WORD; a wrapped
//   result simply lands out of range and is flagged.
//
//   Ports:
//     pc             in   WORD  current program counter
//     uncond_branch  in   1     B instruction
//     cond_branch    in   1     CBZ/CBNZ instruction
//     cond_met       in   1     conditional branch is taken
//     reg_branch     in   1     BR instruction
//     branch_offset  in   WORD  signed word offset
//     reg_target     in   WORD  byte target for BR
//     next_pc        out  WORD  selected next PC
//     bad_target     out  1     next_pc misaligned or beyond instruction memory
// -----------------------------------------------------------------------------
module next_pc_calc
  import fetch_sequencer_pkg::*;
#(
  parameter int WORD      = WORD_BITS,
  parameter int IMEM_SIZE = 1024
) (
  input  logic [WORD-1:0] pc,
  input  logic            uncond_branch,
  input  logic            cond_branch,
  input  logic            cond_met,
  input  logic            reg_branch,
  input  logic [WORD-1:0] branch_offset,
  input  logic [WORD-1:0] reg_target,
  output logic [WORD-1:0] next_pc,
  output logic            bad_target
);

  // First byte address past the end of instruction memory.
  localparam logic [WORD-1:0] PC_LIMIT = WORD'(IMEM_SIZE * PC_INC);

  logic [WORD-1:0] seq_pc;
  logic [WORD-1:0] rel_pc;

  // Shifting left by two drops the top offset bits, which is exactly the
  // modulo-2^WORD behaviour wanted for the relative target.
  assign seq_pc = pc + WORD'(PC_INC);
  assign rel_pc = pc + (branch_offset << 2);

  always_comb begin
    next_pc = seq_pc;
    if (reg_branch) begin
      next_pc = reg_target;
    end else if (uncond_branch) begin
      next_pc = rel_pc;
    end else if (cond_branch && cond_met) begin
      next_pc = rel_pc;
    end
  end

  assign bad_target = (next_pc[1:0] != 2'b00) || (next_pc >= PC_LIMIT);

endmodule : next_pc_calc

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Owns the program counter of a non-pipelined core and sequences
//   fetch/issue against a synchronous instruction memory with a one-cycle
//   registered read. In FETCH the memory captures the word at pc; in ISSUE
//   the word is valid and held until the core retires it with instr_done.
//   The next PC is then selected (sequential / relative / register) and
//   checked; a bad target parks the sequencer in a sticky FAULT state that
//   only reset leaves.
//
//   Ports:
//     clk            in   1     rising-edge clock, shared with instruction memory
//     reset_n        in   1     asynchronous active-low reset
//     enable         in   1     run permission, gates FETCH -> ISSUE
//     instr_done     in   1     one-cycle retire pulse, branch inputs valid
//     uncond_branch  in   1     B instruction
//     cond_branch    in   1     CBZ/CBNZ instruction
//     cond_met       in   1     conditional branch taken
//     reg_branch     in   1     BR instruction
//     branch_offset  in   WORD  signed, sign-extended word offset
//     reg_target     in   WORD  byte target for BR
//     pc             out  WORD  current program counter
//     imem_addr      out  WORD  instruction memory address (same as pc)
//     instr_valid    out  1     memory output corresponds to pc
//     fault          out  1     sticky bad-target indication
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              WORD      = WORD_BITS,
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter int              IMEM_SIZE = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            instr_done,
  input  logic            uncond_branch,
  input  logic            cond_branch,
  input  logic            cond_met,
  input  logic            reg_branch,
  input  logic [WORD-1:0] branch_offset,
  input  logic [WORD-1:0] reg_target,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] imem_addr,
  output logic            instr_valid,
  output logic            fault
);

  fetch_state_e    state_reg;
  fetch_state_e    state_next;
  logic [WORD-1:0] pc_reg;
  logic [WORD-1:0] pc_next;

  logic [WORD-1:0] calc_pc;
  logic            calc_bad;

  next_pc_calc #(
    .WORD      (WORD),
    .IMEM_SIZE (IMEM_SIZE)
  ) u_next_pc_calc (
    .pc            (pc_reg),
    .uncond_branch (uncond_branch),
    .cond_branch   (cond_branch),
    .cond_met      (cond_met),
    .reg_branch    (reg_branch),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .next_pc       (calc_pc),
    .bad_target    (calc_bad)
  );

  // State and PC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FETCH_S;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next-state and next-PC logic. pc only moves on a clean retire; a bad
  // target leaves it pointing at the instruction that produced the fault.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      FETCH_S: begin
        if (enable) begin
          state_next = ISSUE_S;
        end
      end
      ISSUE_S: begin
        if (instr_done) begin
          if (calc_bad) begin
            state_next = FAULT_S;
          end else begin
            state_next = FETCH_S;
            pc_next    = calc_pc;
          end
        end
      end
      FAULT_S: begin
        state_next = FAULT_S;
      end
      default: begin
        // Unused encoding: treat as a fault rather than guess a PC.
        state_next = FAULT_S;
      end
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state_reg)
      ISSUE_S: instr_valid = 1'b1;
      FETCH_S: instr_valid = 1'b0;
      default: fault       = 1'b1;
    endcase
  end

  assign pc        = pc_reg;
  assign imem_addr = pc_reg;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer (WORD=64, RESET_PC=0,
//   IMEM_SIZE=1024). Directed scenarios followed by a randomized run checked
//   against a small reference model of the next-PC rules.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int          WORD     = 64;
  localparam int          IMEM     = 1024;
  localparam logic [63:0] RST_PC   = 64'h0;
  localparam logic [63:0] MEM_END  = 64'd4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        instr_done = 1'b0;
  logic        uncond_branch = 1'b0;
  logic        cond_branch = 1'b0;
  logic        cond_met = 1'b0;
  logic        reg_branch = 1'b0;
  logic [63:0] branch_offset = '0;
  logic [63:0] reg_target = '0;
  logic [63:0] pc;
  logic [63:0] imem_addr;
  logic        instr_valid;
  logic        fault;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_pc   = RST_PC;
  bit          exp_fault = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .WORD      (WORD),
    .RESET_PC  (RST_PC),
    .IMEM_SIZE (IMEM)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .instr_done    (instr_done),
    .uncond_branch (uncond_branch),
    .cond_branch   (cond_branch),
    .cond_met      (cond_met),
    .reg_branch    (reg_branch),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .pc            (pc),
    .imem_addr     (imem_addr),
    .instr_valid   (instr_valid),
    .fault         (fault)
  );

  // Reference rule: register target beats relative beats sequential; the
  // relative target is pc plus four bytes per offset word; anything not
  // word aligned or at/after the end of memory is a bad target.
  function automatic void ref_next(input logic [63:0] cur, input bit u, input bit c,
                                   input bit m, input bit r, input logic [63:0] off,
                                   input logic [63:0] tgt, output logic [63:0] nxt,
                                   output bit bad);
    if (r)              nxt = tgt;
    else if (u)         nxt = cur + off * 64'd4;
    else if (c && m)    nxt = cur + off * 64'd4;
    else                nxt = cur + 64'd4;
    bad = ((nxt % 64'd4) != 0) || (nxt >= MEM_END);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_branch();
    uncond_branch = 1'b0;
    cond_branch   = 1'b0;
    cond_met      = 1'b0;
    reg_branch    = 1'b0;
    branch_offset = '0;
    reg_target    = '0;
  endtask

  // Asynchronous reset, checked while still asserted, released one edge later.
  task automatic do_reset(input string tag);
    instr_done = 1'b0;
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (pc !== RST_PC || fault !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL %s_reset: pc=%h addr=%h fault=%b valid=%b, want pc=%h fault=0 valid=0",
               tag, pc, imem_addr, fault, instr_valid, RST_PC);
    end
    step();
    reset_n = 1'b1;
    exp_pc = RST_PC;
    exp_fault = 1'b0;
  endtask

  // From FETCH: hold enable low for 'stall' cycles, then enter ISSUE.
  task automatic enter_issue(input int stall, input string tag);
    enable = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      n_checks++;
      if (instr_valid !== 1'b0 || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL %s_stall: valid=%b pc=%h, want valid=0 pc=%h", tag, instr_valid, pc, exp_pc);
      end
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (instr_valid !== 1'b1 || pc !== exp_pc || imem_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL %s_issue: valid=%b pc=%h addr=%h, want valid=1 pc=%h",
               tag, instr_valid, pc, imem_addr, exp_pc);
    end
  endtask

  // In ISSUE: retire with the given branch inputs and check the result.
  task automatic retire(input bit u, input bit c, input bit m, input bit r,
                        input logic [63:0] off, input logic [63:0] tgt, input string tag);
    logic [63:0] nxt;
    bit          bad;
    ref_next(exp_pc, u, c, m, r, off, tgt, nxt, bad);
    uncond_branch = u; cond_branch = c; cond_met = m; reg_branch = r;
    branch_offset = off; reg_target = tgt;
    instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    clear_branch();
    if (bad) exp_fault = 1'b1;
    else     exp_pc = nxt;
    n_checks++;
    if (pc !== exp_pc || instr_valid !== 1'b0 || fault !== exp_fault) begin
      n_fail++;
      $display("FAIL %s_retire: pc=%h valid=%b fault=%b, want pc=%h valid=0 fault=%b",
               tag, pc, instr_valid, fault, exp_pc, exp_fault);
    end else begin
      $display("retire %s: pc=%h fault=%b", tag, pc, fault);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    do_reset("rst");
    n_checks++;
    if (instr_valid !== 1'b0 || pc !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_fetch: valid=%b pc=%h, want valid=0 pc=0", instr_valid, pc);
    end
    enter_issue(0, "rst");
    retire(0, 0, 0, 0, 64'd0, 64'd0, "seq");
    n_checks++;
    if (pc !== 64'h4) begin
      n_fail++;
      $display("FAIL seq_pc: pc=%h, want 4", pc);
    end
    enter_issue(0, "seq");
  endtask

  task automatic test_branches();
    retire(0, 0, 0, 1, 64'd0, 64'h10, "to10");
    enter_issue(0, "b1");
    retire(1, 0, 0, 0, -64'sd2, 64'd0, "b_m2");
    n_checks++;
    if (pc !== 64'h08) begin n_fail++; $display("FAIL b_m2_pc: pc=%h, want 8", pc); end
    enter_issue(0, "b2");
    retire(0, 1, 0, 0, 64'd7, 64'd0, "cb_nt");
    n_checks++;
    if (pc !== 64'h0C) begin n_fail++; $display("FAIL cb_nt_pc: pc=%h, want c", pc); end
    enter_issue(0, "b3");
    retire(0, 1, 1, 0, 64'd3, 64'd0, "cb_t");
    n_checks++;
    if (pc !== 64'h18) begin n_fail++; $display("FAIL cb_t_pc: pc=%h, want 18", pc); end
    enter_issue(0, "b4");
    retire(0, 0, 0, 1, 64'd0, 64'h20, "to20");
    enter_issue(0, "b5");
    retire(1, 0, 0, 1, 64'd5, 64'h100, "prio");
    n_checks++;
    if (pc !== 64'h100) begin n_fail++; $display("FAIL prio_pc: pc=%h, want 100", pc); end
    enter_issue(0, "b6");
  endtask

  task automatic test_fault();
    retire(0, 0, 0, 1, 64'd0, 64'h20, "f_to20");
    enter_issue(0, "f1");
    retire(0, 0, 0, 1, 64'd0, 64'h102, "misal");
    // Further retire pulses in FAULT must change nothing.
    for (int i = 0; i < 3; i++) begin
      reg_branch = 1'b1; reg_target = 64'h40; instr_done = 1'b1;
      step();
      instr_done = 1'b0; clear_branch();
      n_checks++;
      if (pc !== 64'h20 || fault !== 1'b1 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_sticky: pc=%h fault=%b valid=%b, want pc=20 fault=1 valid=0",
                 pc, fault, instr_valid);
      end
    end
    do_reset("f");
    enter_issue(0, "f2");
    retire(0, 0, 0, 1, 64'd0, MEM_END, "range");
    n_checks++;
    if (fault !== 1'b1 || pc !== 64'h0) begin
      n_fail++; $display("FAIL range_fault: fault=%b pc=%h, want fault=1 pc=0", fault, pc);
    end
    // Sequential step off the last word faults rather than wrapping.
    do_reset("f3");
    enter_issue(0, "f3");
    retire(0, 0, 0, 1, 64'd0, 64'hFFC, "last");
    enter_issue(0, "f4");
    retire(0, 0, 0, 0, 64'd0, 64'd0, "past_end");
    // Backward branch below zero wraps and lands out of range.
    do_reset("f5");
    enter_issue(0, "f5");
    retire(1, 0, 0, 0, -64'sd1, 64'd0, "wrap");
  endtask

  task automatic test_enable();
    enable = 1'b0;
    do_reset("en");
    enter_issue(5, "en");
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (instr_valid !== 1'b1 || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL en_hold: valid=%b pc=%h, want valid=1 pc=%h", instr_valid, pc, exp_pc);
      end
    end
    retire(0, 0, 0, 0, 64'd0, 64'd0, "en_ret");
    step();
    n_checks++;
    if (instr_valid !== 1'b0 || pc !== 64'h4) begin
      n_fail++;
      $display("FAIL en_gate: valid=%b pc=%h, want valid=0 pc=4", instr_valid, pc);
    end
    enter_issue(1, "en2");
  endtask

  task automatic test_reset_mid_issue();
    do_reset("m");
    enter_issue(0, "m");
    retire(0, 0, 0, 1, 64'd0, 64'h40, "to40");
    enter_issue(0, "m2");
    reg_branch = 1'b1; reg_target = 64'h80; instr_done = 1'b1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pc !== RST_PC || fault !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: pc=%h fault=%b valid=%b, want pc=%h fault=0 valid=0",
               pc, fault, instr_valid, RST_PC);
    end
    step();
    instr_done = 1'b0; clear_branch();
    reset_n = 1'b1;
    exp_pc = RST_PC; exp_fault = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || pc !== RST_PC) begin
      n_fail++;
      $display("FAIL mid_fetch: valid=%b pc=%h, want valid=0 pc=%h", instr_valid, pc, RST_PC);
    end
    enter_issue(0, "m3");
  endtask

  task automatic test_random();
    int          so;
    int          sel;
    logic [63:0] off;
    logic [63:0] tgt;
    bit          u, c, m, r;
    do_reset("rnd");
    enter_issue(0, "rnd");
    for (int n = 0; n < 300; n++) begin
      // Idle ISSUE cycles with junk branch inputs must not move anything.
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        enable = $urandom_range(0, 1) == 1; reg_branch = 1'b1; uncond_branch = 1'b1;
        reg_target = 64'($urandom);
        step();
        clear_branch();
        n_checks++;
        if (instr_valid !== 1'b1 || pc !== exp_pc) begin
          n_fail++;
          $display("FAIL rnd_hold: valid=%b pc=%h, want valid=1 pc=%h", instr_valid, pc, exp_pc);
        end
      end
      so = int'($urandom_range(0, 40)) - 20;
      off = 64'(longint'(so));
      sel = int'($urandom_range(0, 19));
      tgt = 64'($urandom_range(0, IMEM - 1)) * 64'd4;
      if (sel == 0) tgt = tgt + 64'($urandom_range(1, 3));
      if (sel == 1) tgt = MEM_END + 64'($urandom_range(0, 64)) * 64'd4;
      u = $urandom_range(0, 3) == 0;
      c = $urandom_range(0, 1) == 1;
      m = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 4) == 0 || sel < 2;
      retire(u, c, m, r, off, tgt, "rnd");
      if (exp_fault) begin
        do_reset("rnd_f");
      end
      enter_issue(int'($urandom_range(0, 2)), "rnd");
    end
  endtask

  initial begin
    clear_branch();
    #12;
    test_reset();
    test_branches();
    test_fault();
    test_enable();
    test_reset_mid_issue();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_sequencer
